// File: rtl/gate_selftest_if.sv
// Control/status and gate-block bus between the self-test sequencer and its surroundings.
// The slave side is the sequencer; the master side is the gate block plus whoever issues start.
interface gate_selftest_if #(
    parameter int ERR_W = 5
);
    logic             start;
    logic             a_out;
    logic             b_out;
    logic [6:0]       gate_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [6:0]       fail_mask;
    logic [ERR_W-1:0] err_count;

    modport master (
        output start,
        output gate_in,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  err_count
    );

    modport slave (
        input  start,
        input  gate_in,
        output a_out,
        output b_out,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output err_count
    );
endinterface

// File: rtl/gate_selftest.sv
// Self-test sequencer for the two-input gate block: walks a/b through 00,01,10,11,
// compares the seven gate outputs against a truth table and accumulates failures.
module gate_selftest #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    gate_selftest_if.slave bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SUM_W = ERR_W + 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [6:0]       fail_mask_q;
    logic [ERR_W-1:0] err_count_q;

    logic [6:0]       expected_d;
    logic [6:0]       mism_d;
    logic [6:0]       fail_mask_d;
    logic [2:0]       pop_d;
    logic [SUM_W-1:0] sum_d;
    logic [ERR_W-1:0] err_count_d;

    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 7; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Bit order: [0]=and [1]=or [2]=not(a) [3]=nand [4]=nor [5]=xor [6]=xnor
    always_comb begin
        expected_d = 7'h00;
        case (idx_q)
            2'd0:    expected_d = 7'h5C;
            2'd1:    expected_d = 7'h2E;
            2'd2:    expected_d = 7'h2A;
            default: expected_d = 7'h43;
        endcase
    end

    assign mism_d      = bus.gate_in ^ expected_d;
    assign fail_mask_d = fail_mask_q | mism_d;
    assign pop_d       = popcount7(mism_d);
    assign sum_d       = SUM_W'(err_count_q) + SUM_W'(pop_d);
    assign err_count_d = (sum_d > SUM_W'(ERR_MAX)) ? ERR_MAX : sum_d[ERR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 7'h00;
            err_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q     <= SETTLE;
                        idx_q       <= 2'd0;
                        cnt_q       <= '0;
                        a_q         <= 1'b0;
                        b_q         <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_mask_q <= 7'h00;
                        err_count_q <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    fail_mask_q <= fail_mask_d;
                    err_count_q <= err_count_d;
                    if (idx_q != 2'd3) begin
                        // Next vector is driven straight from idx so a/b stay in step with it.
                        idx_q      <= idx_q + 2'd1;
                        {a_q, b_q} <= idx_q + 2'd1;
                        cnt_q      <= '0;
                        state_q    <= SETTLE;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_mask_d == 7'h00);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_gate_selftest.sv
// Bench for gate_selftest: behavioural gate block with fault injection, a result
// scoreboard per DUT, and directed timing/reset checks.
module tb_gate_selftest;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_selftest_if #(.ERR_W(5)) bus0 ();
    gate_selftest_if #(.ERR_W(2)) bus1 ();

    gate_selftest #(.SETTLE_CYCLES(2), .ERR_W(5)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    gate_selftest #(.SETTLE_CYCLES(2), .ERR_W(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // Gate block model with per-output stuck-at-0 and inversion faults.
    logic [6:0] stuck0 = 7'h00;
    logic [6:0] inv0   = 7'h00;
    logic [6:0] inv1   = 7'h00;

    function automatic logic [6:0] gates(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    assign bus0.gate_in = (gates(bus0.a_out, bus0.b_out) & ~stuck0) ^ inv0;
    assign bus1.gate_in = gates(bus1.a_out, bus1.b_out) ^ inv1;

    typedef struct {
        logic [6:0] fm;
        int         ec;
        logic       ps;
        int         acc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitors: pop the expected result whenever done rises.
    logic done0_prev = 1'b0;
    logic done1_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (bus0.done && !done0_prev) begin
            if (sb0.size() == 0) begin
                check("dut0_unexpected_done", 1, 0);
            end else begin
                e = sb0.pop_front();
                check("dut0_fail_mask", int'(bus0.fail_mask), int'(e.fm));
                check("dut0_err_count", int'(bus0.err_count), e.ec);
                check("dut0_pass", int'(bus0.pass), int'(e.ps));
                check("dut0_latency", cyc - e.acc, 12);
                $display("dut0 result fail_mask=%02h err_count=%0d pass=%0d latency=%0d",
                         bus0.fail_mask, bus0.err_count, bus0.pass, cyc - e.acc);
            end
        end
        done0_prev = bus0.done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus1.done && !done1_prev) begin
            if (sb1.size() == 0) begin
                check("dut1_unexpected_done", 1, 0);
            end else begin
                e = sb1.pop_front();
                check("dut1_fail_mask", int'(bus1.fail_mask), int'(e.fm));
                check("dut1_err_count", int'(bus1.err_count), e.ec);
                check("dut1_pass", int'(bus1.pass), int'(e.ps));
                check("dut1_latency", cyc - e.acc, 12);
                $display("dut1 result fail_mask=%02h err_count=%0d pass=%0d latency=%0d",
                         bus1.fail_mask, bus1.err_count, bus1.pass, cyc - e.acc);
            end
        end
        done1_prev = bus1.done;
    end

    // One-cycle start pulse; when accepted is set the expected result is queued.
    task automatic pulse_start(input int which, input bit accepted,
                               input logic [6:0] fm, input int ec, input logic ps);
        exp_t e;
        @(negedge clk);
        if (which == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
        if (accepted) begin
            e.fm = fm; e.ec = ec; e.ps = ps; e.acc = cyc + 1;
            if (which == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic drain(input int which);
        for (int n = 0; n < 60; n++) begin
            if ((which == 0 ? sb0.size() : sb1.size()) == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        if (which == 0) begin
            check("dut0_sb_drained", sb0.size(), 0);
            sb0.delete();
        end else begin
            check("dut1_sb_drained", sb1.size(), 0);
            sb1.delete();
        end
    endtask

    function automatic int outs0();
        return int'({bus0.a_out, bus0.b_out, bus0.busy, bus0.done, bus0.pass,
                     bus0.fail_mask, bus0.err_count});
    endfunction

    function automatic int outs1();
        return int'({bus1.a_out, bus1.b_out, bus1.busy, bus1.done, bus1.pass,
                     bus1.fail_mask, bus1.err_count});
    endfunction

    initial begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outs0", outs0(), 0);
        check("reset_outs1", outs1(), 0);

        // 1: correct model, per-cycle a/b stepping and busy.
        pulse_start(0, 1'b1, 7'h00, 0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("s1_ab_k%0d", k), int'({bus0.a_out, bus0.b_out}), k / 3);
            check($sformatf("s1_busy_k%0d", k), int'(bus0.busy), 1);
            @(negedge clk);
        end
        check("s1_busy_end", int'(bus0.busy), 0);
        check("s1_ab_end", int'({bus0.a_out, bus0.b_out}), 3);
        drain(0);
        $display("scenario 1 done");

        // 2: xor stuck at 0.
        stuck0 = 7'b0100000;
        pulse_start(0, 1'b1, 7'b0100000, 2, 1'b0);
        drain(0);
        stuck0 = 7'h00;
        $display("scenario 2 done");

        // 3: not inverted, then a clean rerun from DONE.
        inv0 = 7'b0000100;
        pulse_start(0, 1'b1, 7'b0000100, 4, 1'b0);
        drain(0);
        inv0 = 7'h00;
        pulse_start(0, 1'b1, 7'h00, 0, 1'b1);
        check("s3_done_dropped", int'(bus0.done), 0);
        check("s3_mask_cleared", int'(bus0.fail_mask), 0);
        check("s3_count_cleared", int'(bus0.err_count), 0);
        drain(0);
        $display("scenario 3 done");

        // 4: start re-pulsed while busy must be ignored.
        pulse_start(0, 1'b1, 7'h00, 0, 1'b1);
        @(negedge clk);
        pulse_start(0, 1'b0, 7'h00, 0, 1'b0);
        repeat (2) @(negedge clk);
        pulse_start(0, 1'b0, 7'h00, 0, 1'b0);
        drain(0);
        $display("scenario 4 done");

        // 5: asynchronous reset during vector 10.
        pulse_start(0, 1'b1, 7'h00, 0, 1'b1);
        repeat (7) @(negedge clk);
        check("s5_vec_before_rst", int'({bus0.a_out, bus0.b_out}), 2);
        #2 rst_n = 1'b0;
        sb0.delete();
        #1 check("s5_async_reset_outs", outs0(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("s5_idle_after_release", outs0(), 0);
        pulse_start(0, 1'b1, 7'h00, 0, 1'b1);
        drain(0);
        $display("scenario 5 done");

        // 6: ERR_W=2, every output inverted -> count saturates at 3.
        inv1 = 7'h7F;
        pulse_start(1, 1'b1, 7'h7F, 3, 1'b0);
        drain(1);
        $display("scenario 6 done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gate_selftest.md
Name: gate_selftest

Overview:
Built-in self-test sequencer for the two-input gate block. Drives the gate block's a/b inputs through all four input combinations and captures its seven gate outputs. Compares each capture against an internal truth table and reports pass/fail, a per-gate failure mask and a mismatch count. Sits directly upstream (drives a, b) and downstream (consumes the outputs) of the gate block.

Parameters:
SETTLE_CYCLES, 2, cycles a_out/b_out are held stable before gate_in is sampled; legal range >= 1
ERR_W, 5, width of err_count; counts per-bit mismatches, saturating

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to run the self-test; sampled only when not busy
a_out  output  1  drives gate block input a
b_out  output  1  drives gate block input b
gate_in  input  7  gate block outputs: [0]=and [1]=or [2]=not(a) [3]=nand [4]=nor [5]=xor [6]=xnor
busy  output  1  test in progress
done  output  1  test complete; held until next accepted start
pass  output  1  valid when done=1; 1 = no mismatches
fail_mask  output  7  sticky OR of mismatching gate_in bits, same bit order as gate_in
err_count  output  ERR_W  total mismatched bits across all vectors, saturating at 2^ERR_W-1

Behaviour:
- One clock. Reset is asynchronous and active-low. All outputs and all state are 0 in reset: a_out, b_out, busy, done, pass, fail_mask, err_count. FSM resets to IDLE.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- Vector index idx is 2 bits and runs 0..3. {a_out,b_out} = idx, in the order 00, 01, 10, 11.
- Expected gate_in per vector: 00 -> 7'h5C, 01 -> 7'h2E, 10 -> 7'h2A, 11 -> 7'h43.
- Start is accepted in IDLE or DONE. At the accepting edge:
  - clear fail_mask, err_count, done and pass
  - set busy=1, idx=0, a_out=b_out=0, settle counter=0
  - go to SETTLE
- SETTLE: the counter increments each cycle. On the edge where counter == SETTLE_CYCLES-1, go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): at its closing edge, compute mism = gate_in ^ expected(idx).
  - fail_mask |= mism
  - err_count += popcount(mism), saturating
  - If idx < 3: idx++, update a_out/b_out, clear the counter, go to SETTLE.
  - If idx == 3: go to DONE.
- a_out/b_out change only at the CHECK-to-SETTLE edge or at start acceptance. They are stable throughout SETTLE and CHECK.
- DONE: busy=0, done=1, pass = (fail_mask == 0), all computed from the final-vector update. a_out/b_out hold the last vector (1,1). DONE is held indefinitely.
- Latency: done rises at edge E + 4*(SETTLE_CYCLES+1), where E is the start-accepting edge. With the default this is 12 cycles.
- Start asserted while busy is ignored: no restart, no state change.
- Start in DONE restarts the test immediately. done/pass drop at the accepting edge.
- rst_n falling mid-test asynchronously forces the reset values. A new start is required after reset release.
- gate_in is used only in CHECK and ignored in all other states.

Test Plan:
1. Correct gate model, default params, start pulse -> busy=1 for 12 cycles; a_out/b_out step 00, 01, 10, 11, each held 3 cycles; done=1, pass=1, fail_mask=0, err_count=0.
2. xor_out stuck at 0 -> fail_mask=7'b0100000, err_count=2, pass=0.
3. not_out inverted -> fail_mask=7'b0000100, err_count=4, pass=0. Then a second start with a correct model -> counters cleared, pass=1.
4. Start re-pulsed at cycles 3 and 7 of a run -> ignored; done still at cycle 12 with results identical to scenario 1.
5. rst_n low during vector 10 -> all outputs 0 immediately. After release, nothing happens until start; a subsequent run completes normally.
6. ERR_W=2, all seven gate outputs inverted -> fail_mask=7'h7F, err_count=3 (saturated; raw count 28), pass=0.
